// File: rtl/chess_mem_pkg.sv
// Shared types for the board-memory arbiter.
// Owner tags travel with reads so returned data reaches the right requester.
package chess_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    OWN_VGA,
    OWN_CPU
  } owner_t;

  typedef enum logic {
    S_NORMAL,
    S_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/chess_mem_rd_tag_pipe.sv
// Read-tag delay line: matches an accepted read to its mem_q slot.
// Depth covers the address register plus the memory read latency.
module rd_tag_pipe
  import chess_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/chess_mem_arbiter.sv
// Board-memory arbiter: display-first, with starvation guard and
// bounded lock so game logic can do atomic read-modify-write moves.
module chess_mem_arbiter
  import chess_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  arb_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              force_cpu;
  logic              vga_xfer, cpu_xfer;
  rd_tag_t           tag_in, tag_out;

  always_comb begin
    state_nxt = state;
    vga_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    force_cpu = 1'b0;
    unique case (state)
      S_NORMAL: begin
        force_cpu = cpu_req && (wait_cnt == WAIT_W'(MAX_WAIT));
        vga_gnt   = vga_req & ~force_cpu;
        cpu_gnt   = cpu_req & (force_cpu | ~vga_req);
        if (cpu_gnt && cpu_lock)
          state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        cpu_gnt = cpu_req;
        // Lock ends on release or after LOCK_MAX cycles, whichever first
        if (!cpu_lock || lock_cnt == LOCK_W'(LOCK_MAX - 1))
          state_nxt = S_NORMAL;
      end
      default: state_nxt = S_NORMAL;
    endcase
  end

  assign vga_xfer = vga_req & vga_gnt;
  assign cpu_xfer = cpu_req & cpu_gnt;

  assign tag_in.valid = vga_xfer | (cpu_xfer & ~cpu_we);
  assign tag_in.owner = cpu_xfer ? OWN_CPU : OWN_VGA;

  rd_tag_pipe #(
    .DEPTH (1 + RD_LAT)
  ) u_tag_pipe (
    .clk     (iCLK),
    .rst_n   (iRST_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state      <= S_NORMAL;
      wait_cnt   <= '0;
      lock_cnt   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vga_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (cpu_req && !cpu_gnt) begin
        if (wait_cnt != WAIT_W'(MAX_WAIT))
          wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (state == S_NORMAL)
        lock_cnt <= '0;
      else
        lock_cnt <= lock_cnt + LOCK_W'(1);
      mem_wren <= cpu_xfer & cpu_we;
      if (cpu_xfer) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (vga_xfer) begin
        mem_addr <= vga_addr;
      end
      vga_rvalid <= tag_out.valid && tag_out.owner == OWN_VGA;
      cpu_rvalid <= tag_out.valid && tag_out.owner == OWN_CPU;
      if (tag_out.valid && tag_out.owner == OWN_VGA)
        vga_rdata <= mem_q;
      if (tag_out.valid && tag_out.owner == OWN_CPU)
        cpu_rdata <= mem_q;
    end
  end

endmodule

// File: tb/tb_chess_mem_arbiter.sv
// Bench for chess_mem_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model and a board memory.
module tb_chess_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MAX_WAIT = 8;
  localparam int LOCK_MAX = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vga_req, vga_gnt, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_q;
  logic          mem_wren;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          due;
    bit          cpu;
    logic [31:0] data;
  } ret_t;

  logic [31:0] sh [int];
  ret_t        pend [$];

  always #5 clk = ~clk;

  chess_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1),
    .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  // Board memory: unwritten words read as addr*3, one-cycle sync read
  logic [DW-1:0] mem [4096];
  bit            wr_ok [4096];

  always @(posedge clk) begin
    if (mem_wren) begin
      mem[mem_addr]   <= mem_wdata;
      wr_ok[mem_addr] <= 1'b1;
    end
    mem_q <= wr_ok[mem_addr] ? mem[mem_addr] : {20'd0, mem_addr} * 32'd3;
  end

  function automatic logic [31:0] sh_rd(input logic [AW-1:0] a);
    return sh.exists(int'(a)) ? sh[int'(a)] : {20'd0, a} * 32'd3;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    vga_req = 0; vga_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_lock = 0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [127:0] obs;
    do_reset();
    @(negedge clk);
    obs = {mem_addr, mem_wdata, mem_wren, vga_rvalid, cpu_rvalid,
           vga_rdata, cpu_rdata, vga_gnt, cpu_gnt};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vga_stream();
    logic        e_g, e_v;
    logic [31:0] e_d;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      vga_req  = (i < 10);
      vga_addr = AW'(i);
      @(negedge clk);
      e_g = (i < 10);
      e_v = (i >= LAT && i < 10 + LAT);
      e_d = (i < LAT) ? 32'd0 : 32'(((i - LAT) > 9 ? 9 : (i - LAT)) * 3);
      vectors++;
      if (vga_gnt !== e_g) begin
        miscompares++;
        $display("FAIL stream_gnt c%0d: got %b want %b", i, vga_gnt, e_g);
      end
      vectors++;
      if (vga_rvalid !== e_v || vga_rdata !== e_d) begin
        miscompares++;
        $display("FAIL stream_rd c%0d: got %b/%h want %b/%h",
                 i, vga_rvalid, vga_rdata, e_v, e_d);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_starvation();
    logic e_vg, e_cg, e_vv, e_cv;
    int   j;
    do_reset();
    cpu_addr = 12'h040;
    cpu_we   = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vga_req  = 1'b1;
      vga_addr = AW'(i <= 8 ? i : i - 1);
      cpu_req  = (i <= 8);
      @(negedge clk);
      e_cg = (i == 8);
      e_vg = (i != 8);
      j = i - LAT;
      e_vv = (i >= LAT && j != 8);
      e_cv = (i == 8 + LAT);
      vectors++;
      if ({vga_gnt, cpu_gnt} !== {e_vg, e_cg}) begin
        miscompares++;
        $display("FAIL starve_gnt c%0d: got %b%b want %b%b",
                 i, vga_gnt, cpu_gnt, e_vg, e_cg);
      end
      vectors++;
      if ({vga_rvalid, cpu_rvalid} !== {e_vv, e_cv}) begin
        miscompares++;
        $display("FAIL starve_rvalid c%0d: got %b%b want %b%b",
                 i, vga_rvalid, cpu_rvalid, e_vv, e_cv);
      end
      if (e_vv) begin
        vectors++;
        if (vga_rdata !== 32'((j < 8 ? j : j - 1) * 3)) begin
          miscompares++;
          $display("FAIL starve_vdata c%0d: got %h", i, vga_rdata);
        end
      end
      if (e_cv) begin
        vectors++;
        if (cpu_rdata !== 32'h0C0) begin
          miscompares++;
          $display("FAIL starve_cdata: got %h want 000000c0", cpu_rdata);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock_rmw();
    logic e_cg;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      vga_req   = 1'b1;
      vga_addr  = 12'h100;
      cpu_req   = (i <= 9);
      cpu_we    = (i <= 8);
      cpu_lock  = (i <= 8);
      cpu_addr  = 12'h012;
      cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      e_cg = (i == 8 || i == 9);
      vectors++;
      if ({vga_gnt, cpu_gnt} !== {~e_cg, e_cg}) begin
        miscompares++;
        $display("FAIL rmw_gnt c%0d: got %b%b want %b%b",
                 i, vga_gnt, cpu_gnt, ~e_cg, e_cg);
      end
      if (i == 11 || i == 12) begin
        vectors++;
        if (cpu_rvalid !== (i == 12) ||
            (i == 12 && cpu_rdata !== 32'hDEADBEEF)) begin
          miscompares++;
          $display("FAIL rmw_read c%0d: got %b/%h want %b/deadbeef",
                   i, cpu_rvalid, cpu_rdata, i == 12);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock_timeout();
    logic e_cg;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      vga_req  = 1'b1;
      vga_addr = 12'h101;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_lock = 1'b1;
      cpu_addr = 12'h005;
      @(negedge clk);
      e_cg = (i >= MAX_WAIT && i < MAX_WAIT + 1 + LOCK_MAX);
      vectors++;
      if ({vga_gnt, cpu_gnt} !== {~e_cg, e_cg}) begin
        miscompares++;
        $display("FAIL lock_max c%0d: got %b%b want %b%b",
                 i, vga_gnt, cpu_gnt, ~e_cg, e_cg);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] obs;
    do_reset();
    vga_req  = 1'b1;
    vga_addr = 12'h007;
    @(negedge clk);
    vectors++;
    if (vga_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_gnt: got %b want 1", vga_gnt);
    end
    @(posedge clk); #1;
    vga_req = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      obs = {mem_addr, mem_wdata, mem_wren, vga_rvalid, cpu_rvalid,
             vga_rdata, cpu_rdata};
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL midrst_out c%0d: got %h want 0", i, obs);
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b1; cpu_lock = 1'b1; cpu_we = 1'b1;
    cpu_addr = 12'h0AB; cpu_wdata = 32'h5;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    vga_req = 1'b1;
    rst_n   = 1'b0;
    @(negedge clk);
    vectors++;
    if (vga_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL midlock_held: got %b want 0", vga_gnt);
    end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    cpu_req = 1'b1;
    @(negedge clk);
    vectors++;
    if ({vga_gnt, cpu_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL midlock_rst: got %b%b want 10", vga_gnt, cpu_gnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 12'h0AA; cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_wren, mem_addr, mem_wdata} !== {1'b1, 12'h0AA, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL idle_issue: got %b/%h/%h want 1/0aa/12345678",
               mem_wren, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if ({mem_wren, mem_addr, vga_rvalid, cpu_rvalid, vga_gnt, cpu_gnt}
          !== {1'b0, 12'h0AA, 4'b0000}) begin
        miscompares++;
        $display("FAIL idle_hold c%0d: got %b/%h/%b%b want 0/0aa/00",
                 i, mem_wren, mem_addr, vga_rvalid, cpu_rvalid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int          m_wait, m_left;
    logic        e_vg, e_cg, e_vv, e_cv, v_done, c_done;
    logic [31:0] lv, lc;
    do_reset();
    pend.delete();
    m_wait = 0; m_left = 0; lv = '0; lc = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!vga_req && cyc < 580 && $urandom_range(0, 2) != 0) begin
        vga_req  = 1'b1;
        vga_addr = 12'h200 + AW'($urandom_range(0, 15));
      end
      if (!cpu_req && cyc < 580 && $urandom_range(0, 3) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_lock  = ($urandom_range(0, 3) == 0);
        cpu_addr  = 12'h200 + AW'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      @(negedge clk);
      if (m_left > 0) begin
        e_vg = 1'b0; e_cg = cpu_req;
      end else if (cpu_req && m_wait >= MAX_WAIT) begin
        e_vg = 1'b0; e_cg = 1'b1;
      end else begin
        e_vg = vga_req; e_cg = cpu_req && !vga_req;
      end
      vectors++;
      if ({vga_gnt, cpu_gnt} !== {e_vg, e_cg}) begin
        miscompares++;
        $display("FAIL rnd_gnt c%0d: got %b%b want %b%b",
                 cyc, vga_gnt, cpu_gnt, e_vg, e_cg);
      end
      e_vv = 1'b0; e_cv = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].cpu) begin e_cv = 1'b1; lc = pend[0].data; end
        else begin e_vv = 1'b1; lv = pend[0].data; end
        void'(pend.pop_front());
      end
      vectors++;
      if ({vga_rvalid, cpu_rvalid} !== {e_vv, e_cv} ||
          vga_rdata !== lv || cpu_rdata !== lc) begin
        miscompares++;
        $display("FAIL rnd_rd c%0d: got %b%b %h %h want %b%b %h %h", cyc,
                 vga_rvalid, cpu_rvalid, vga_rdata, cpu_rdata,
                 e_vv, e_cv, lv, lc);
      end
      v_done = e_vg && vga_req;
      c_done = e_cg && cpu_req;
      if (v_done)
        pend.push_back('{cyc + LAT, 1'b0, sh_rd(vga_addr)});
      if (c_done) begin
        if (cpu_we) sh[int'(cpu_addr)] = cpu_wdata;
        else pend.push_back('{cyc + LAT, 1'b1, sh_rd(cpu_addr)});
      end
      m_wait = (cpu_req && !e_cg) ?
               ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
      if (m_left > 0) m_left = cpu_lock ? m_left - 1 : 0;
      else if (c_done && cpu_lock) m_left = LOCK_MAX;
      @(posedge clk); #1;
      if (v_done) vga_req = 1'b0;
      if (c_done) cpu_req = 1'b0;
    end
    vectors++;
    if (pend.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_drain: got %0d pending want 0", pend.size());
    end
  endtask

  initial begin
    test_reset();
    test_vga_stream();
    test_starvation();
    test_lock_rmw();
    test_lock_timeout();
    test_reset_mid();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
